// File: rtl/gf_mult_pipe.sv
// Multi-lane pipelined GF(2^m) multiply / divide / multiply-accumulate with a fixed 3-stage latency.
// Define GF_MULT_PIPE_DZ_EN to add the per-lane divide-by-zero flag output o_dz.
module gf_mult_pipe #(
    parameter int unsigned SYMB_WIDTH = 8,
    parameter int unsigned PRIM_POLY  = 'h11D,
    parameter int unsigned LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_valid,
    output logic                        i_ready,
    input  logic [1:0]                  i_mode,
    input  logic [LANES*SYMB_WIDTH-1:0] i_a,
    input  logic [LANES*SYMB_WIDTH-1:0] i_b,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [LANES*SYMB_WIDTH-1:0] o_p
`ifdef GF_MULT_PIPE_DZ_EN
    ,
    output logic [LANES-1:0]            o_dz
`endif
);

    localparam int unsigned M     = SYMB_WIDTH;
    localparam int unsigned Q     = (1 << M) - 1;
    localparam int unsigned TAB_W = (1 << M) * M;
    localparam logic [M:0]  QV    = (M + 1)'(Q);

    typedef enum logic [1:0] {
        ModeMul    = 2'b00,
        ModeDiv    = 2'b01,
        ModeMac    = 2'b10,
        ModeMacClr = 2'b11
    } mode_e;

    // Antilog table: entry i holds alpha^i, built by repeated multiply-by-x.
    function automatic logic [TAB_W-1:0] gen_exp();
        logic [TAB_W-1:0] tab;
        logic [M:0]       x;
        tab = '0;
        x   = (M + 1)'(1);
        for (int unsigned i = 0; i < Q; i++) begin
            tab[i*M +: M] = x[M-1:0];
            x = {x[M-1:0], 1'b0};
            if (x[M]) x = x ^ PRIM_POLY[M:0];
        end
        return tab;
    endfunction

    function automatic logic [TAB_W-1:0] gen_log();
        logic [TAB_W-1:0] tab;
        logic [TAB_W-1:0] ex;
        tab = '0;
        ex  = gen_exp();
        for (int unsigned i = 0; i < Q; i++) begin
            tab[32'(ex[i*M +: M])*M +: M] = M'(i);
        end
        return tab;
    endfunction

    localparam logic [TAB_W-1:0] EXP_TAB = gen_exp();
    localparam logic [TAB_W-1:0] LOG_TAB = gen_log();

    logic en;

    logic                      s1_valid_q;
    mode_e                     s1_mode_q;
    logic [LANES-1:0][M-1:0]   s1_loga_q, s1_logb_q;
    logic [LANES-1:0]          s1_za_q, s1_zb_q;
    logic [LANES-1:0][M-1:0]   loga_d, logb_d;
    logic [LANES-1:0]          za_d, zb_d;

    logic                      s2_valid_q;
    mode_e                     s2_mode_q;
    logic [LANES-1:0][M-1:0]   s2_e_q;
    logic [LANES-1:0]          s2_z_q;
    logic [LANES-1:0][M-1:0]   e_d;
    logic [LANES-1:0]          z_d;

    logic [LANES-1:0][M-1:0]   acc_q, acc_d, p_d;

    assign en      = !o_valid || o_ready;
    assign i_ready = en;

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            logic [M-1:0] a_sym, b_sym;
            a_sym     = i_a[k*M +: M];
            b_sym     = i_b[k*M +: M];
            loga_d[k] = LOG_TAB[32'(a_sym)*M +: M];
            logb_d[k] = LOG_TAB[32'(b_sym)*M +: M];
            za_d[k]   = (a_sym == '0);
            zb_d[k]   = (b_sym == '0);
        end
    end

    // Division adds the negated log; one conditional subtract suffices since the sum is < 2Q.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            logic [M:0] b_term, sum;
            b_term = (s1_mode_q == ModeDiv) ? (QV - {1'b0, s1_logb_q[k]})
                                            : {1'b0, s1_logb_q[k]};
            sum    = {1'b0, s1_loga_q[k]} + b_term;
            if (sum >= QV) sum = sum - QV;
            e_d[k] = sum[M-1:0];
            z_d[k] = s1_za_q[k] | s1_zb_q[k];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            logic [M-1:0] r;
            r        = s2_z_q[k] ? '0 : EXP_TAB[32'(s2_e_q[k])*M +: M];
            acc_d[k] = acc_q[k];
            p_d[k]   = r;
            case (s2_mode_q)
                ModeMac: begin
                    acc_d[k] = acc_q[k] ^ r;
                    p_d[k]   = acc_q[k] ^ r;
                end
                ModeMacClr: acc_d[k] = r;
                default: ;
            endcase
        end
    end

`ifdef GF_MULT_PIPE_DZ_EN
    logic [LANES-1:0] s2_dz_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_dz_q <= '0;
            o_dz    <= '0;
        end else if (en) begin
            s2_dz_q <= (s1_mode_q == ModeDiv) ? s1_zb_q : '0;
            if (s2_valid_q) o_dz <= s2_dz_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= ModeMul;
            s1_loga_q  <= '0;
            s1_logb_q  <= '0;
            s1_za_q    <= '0;
            s1_zb_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= ModeMul;
            s2_e_q     <= '0;
            s2_z_q     <= '0;
            o_valid    <= 1'b0;
            o_p        <= '0;
            acc_q      <= '0;
        end else if (en) begin
            s1_valid_q <= i_valid;
            s1_mode_q  <= mode_e'(i_mode);
            s1_loga_q  <= loga_d;
            s1_logb_q  <= logb_d;
            s1_za_q    <= za_d;
            s1_zb_q    <= zb_d;
            s2_valid_q <= s1_valid_q;
            s2_mode_q  <= s1_mode_q;
            s2_e_q     <= e_d;
            s2_z_q     <= z_d;
            o_valid    <= s2_valid_q;
            // Accumulators move only when a beat lands in the output register.
            if (s2_valid_q) begin
                o_p   <= p_d;
                acc_q <= acc_d;
            end
        end
    end

endmodule
